// File: rtl/stack_ptr_guarded.sv
// Stack pointer with depth tracking, full/empty flags, sticky overflow/underflow
// detection, guard-or-wrap boundary behaviour and a shadow LIFO that saves and
// restores the pointer across nested interrupts.
//
// Ports:
//   SPG_CLK      clock, all state updates on the rising edge
//   SPG_RST      synchronous active-high reset (overrides every other input)
//   SPG_INC      pop  (pointer + 1)
//   SPG_DEC      push (pointer - 1)
//   SPG_LD       load pointer from SPG_DIN
//   SPG_DIN      load value
//   SPG_SAVE     push current pointer onto the shadow LIFO
//   SPG_RESTORE  pop the shadow LIFO into the pointer
//   SPG_CLR_ERR  clear sticky error flags (a same-cycle error event wins)
//   SPG_DOUT     current pointer (registered)
//   SPG_COUNT    entries in use, (EMPTY_VAL - pointer) mod 2^WIDTH
//   SPG_EMPTY    SPG_COUNT == 0
//   SPG_FULL     SPG_COUNT >= DEPTH
//   SPG_OVF      sticky: push attempted while full
//   SPG_UNF      sticky: pop attempted while empty
//   SPG_SHD_ERR  sticky: SAVE while shadow full or RESTORE while shadow empty
//   SPG_SHD_LVL  occupied shadow entries
module stack_ptr_guarded #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned EMPTY_VAL = 0,
  parameter int unsigned DEPTH     = 255,
  parameter int unsigned WRAP_MODE = 0,
  parameter int unsigned NEST      = 4
) (
  input  logic                      SPG_CLK,
  input  logic                      SPG_RST,
  input  logic                      SPG_INC,
  input  logic                      SPG_DEC,
  input  logic                      SPG_LD,
  input  logic [WIDTH-1:0]          SPG_DIN,
  input  logic                      SPG_SAVE,
  input  logic                      SPG_RESTORE,
  input  logic                      SPG_CLR_ERR,
  output logic [WIDTH-1:0]          SPG_DOUT,
  output logic [WIDTH:0]            SPG_COUNT,
  output logic                      SPG_EMPTY,
  output logic                      SPG_FULL,
  output logic                      SPG_OVF,
  output logic                      SPG_UNF,
  output logic                      SPG_SHD_ERR,
  output logic [$clog2(NEST+1)-1:0] SPG_SHD_LVL
);

  localparam int unsigned LvlW = $clog2(NEST + 1);
  localparam int unsigned CntW = WIDTH + 1;
  localparam logic [WIDTH-1:0] EmptyPtr = WIDTH'(EMPTY_VAL);
  localparam logic [CntW-1:0]  DepthCnt = CntW'(DEPTH);
  localparam logic [LvlW-1:0]  NestLvl  = LvlW'(NEST);
  localparam bit               Wrap     = (WRAP_MODE != 0);

  logic [WIDTH-1:0] ptr_q, ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             shd_err_q, shd_err_d;
  logic [LvlW-1:0]  lvl_q, lvl_d;
  logic [WIDTH-1:0] shadow_q [NEST];

  logic             ovf_evt, unf_evt, shd_evt;
  logic             shd_we;
  logic [WIDTH-1:0] restore_val;

  // Top-of-shadow read: entry lvl_q-1.
  always_comb begin
    restore_val = '0;
    for (int i = 0; i < int'(NEST); i++) begin
      if (LvlW'(i + 1) == lvl_q) restore_val = shadow_q[i];
    end
  end

  always_comb begin
    ptr_d   = ptr_q;
    lvl_d   = lvl_q;
    ovf_evt = 1'b0;
    unf_evt = 1'b0;
    shd_evt = 1'b0;
    shd_we  = 1'b0;

    if (SPG_RESTORE) begin
      // RESTORE masks SAVE and every pointer op, even when it fails.
      if (lvl_q != '0) begin
        ptr_d = restore_val;
        lvl_d = lvl_q - LvlW'(1);
      end else begin
        shd_evt = 1'b1;
      end
    end else begin
      // SAVE captures the pre-update pointer; the pointer op still runs.
      if (SPG_SAVE) begin
        if (lvl_q == NestLvl) begin
          shd_evt = 1'b1;
        end else begin
          shd_we = 1'b1;
          lvl_d  = lvl_q + LvlW'(1);
        end
      end

      if (SPG_LD) begin
        ptr_d = SPG_DIN;
      end else if (SPG_INC) begin
        unf_evt = empty_q;
        if (!empty_q || Wrap) ptr_d = ptr_q + WIDTH'(1);
      end else if (SPG_DEC) begin
        ovf_evt = full_q;
        if (!full_q || Wrap) ptr_d = ptr_q - WIDTH'(1);
      end
    end

    // Count tracks the next pointer so it is coherent with SPG_DOUT.
    cnt_d   = {1'b0, EmptyPtr - ptr_d};
    empty_d = (cnt_d == '0);
    full_d  = (cnt_d >= DepthCnt);

    // Set beats clear.
    ovf_d     = (ovf_q & ~SPG_CLR_ERR) | ovf_evt;
    unf_d     = (unf_q & ~SPG_CLR_ERR) | unf_evt;
    shd_err_d = (shd_err_q & ~SPG_CLR_ERR) | shd_evt;
  end

  always_ff @(posedge SPG_CLK) begin
    if (SPG_RST) begin
      ptr_q     <= EmptyPtr;
      cnt_q     <= '0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      shd_err_q <= 1'b0;
      lvl_q     <= '0;
    end else begin
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      empty_q   <= empty_d;
      full_q    <= full_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      shd_err_q <= shd_err_d;
      lvl_q     <= lvl_d;
    end
  end

  // Shadow contents are not reset; only the level matters after reset.
  always_ff @(posedge SPG_CLK) begin
    if (!SPG_RST && shd_we) begin
      for (int i = 0; i < int'(NEST); i++) begin
        if (LvlW'(i) == lvl_q) shadow_q[i] <= ptr_q;
      end
    end
  end

  assign SPG_DOUT    = ptr_q;
  assign SPG_COUNT   = cnt_q;
  assign SPG_EMPTY   = empty_q;
  assign SPG_FULL    = full_q;
  assign SPG_OVF     = ovf_q;
  assign SPG_UNF     = unf_q;
  assign SPG_SHD_ERR = shd_err_q;
  assign SPG_SHD_LVL = lvl_q;

endmodule

// File: tb/tb_stack_ptr_guarded.sv
`timescale 1ns/1ps
module tb_stack_ptr_guarded;

  localparam int W         = 8;
  localparam int EMPTY_VAL = 0;
  localparam int DEPTH     = 255;
  localparam int NEST      = 4;
  localparam int MASK      = (1 << W) - 1;

  typedef struct {
    int ptr;
    int cnt;
    int lvl;
    bit empty;
    bit full;
    bit ovf;
    bit unf;
    bit shd;
  } exp_t;

  logic clk;
  logic rst, inc, dec, ld, save, restore, clr;
  logic [W-1:0] din;

  // Index 0: guard-mode instance, index 1: wrap-mode instance.
  logic [W-1:0] dout  [2];
  logic [W:0]   cnt   [2];
  logic         empty [2];
  logic         full  [2];
  logic         ovf   [2];
  logic         unf   [2];
  logic         shd   [2];
  logic [2:0]   lvl   [2];

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_ptr [2];
  int m_lvl [2];
  bit m_ovf [2];
  bit m_unf [2];
  bit m_shd [2];
  int m_sh  [2][NEST];

  exp_t exp_q0[$];
  exp_t exp_q1[$];

  stack_ptr_guarded #(
    .WIDTH(W), .EMPTY_VAL(EMPTY_VAL), .DEPTH(DEPTH), .WRAP_MODE(0), .NEST(NEST)
  ) u_guard (
    .SPG_CLK(clk), .SPG_RST(rst), .SPG_INC(inc), .SPG_DEC(dec), .SPG_LD(ld),
    .SPG_DIN(din), .SPG_SAVE(save), .SPG_RESTORE(restore), .SPG_CLR_ERR(clr),
    .SPG_DOUT(dout[0]), .SPG_COUNT(cnt[0]), .SPG_EMPTY(empty[0]), .SPG_FULL(full[0]),
    .SPG_OVF(ovf[0]), .SPG_UNF(unf[0]), .SPG_SHD_ERR(shd[0]), .SPG_SHD_LVL(lvl[0])
  );

  stack_ptr_guarded #(
    .WIDTH(W), .EMPTY_VAL(EMPTY_VAL), .DEPTH(DEPTH), .WRAP_MODE(1), .NEST(NEST)
  ) u_wrap (
    .SPG_CLK(clk), .SPG_RST(rst), .SPG_INC(inc), .SPG_DEC(dec), .SPG_LD(ld),
    .SPG_DIN(din), .SPG_SAVE(save), .SPG_RESTORE(restore), .SPG_CLR_ERR(clr),
    .SPG_DOUT(dout[1]), .SPG_COUNT(cnt[1]), .SPG_EMPTY(empty[1]), .SPG_FULL(full[1]),
    .SPG_OVF(ovf[1]), .SPG_UNF(unf[1]), .SPG_SHD_ERR(shd[1]), .SPG_SHD_LVL(lvl[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Behavioural model: one action per cycle, stack depth from pointer distance.
  task automatic model_step(input int m, input bit r, input bit i, input bit d, input bit l,
                            input int dv, input bit s, input bit rs, input bit c);
    int  depth_now;
    bit  wrap;
    wrap      = (m == 1);
    depth_now = (EMPTY_VAL - m_ptr[m]) & MASK;
    if (r) begin
      m_ptr[m] = EMPTY_VAL;
      m_lvl[m] = 0;
      m_ovf[m] = 0;
      m_unf[m] = 0;
      m_shd[m] = 0;
      return;
    end
    if (c) begin
      m_ovf[m] = 0;
      m_unf[m] = 0;
      m_shd[m] = 0;
    end
    if (rs) begin
      if (m_lvl[m] > 0) begin
        m_lvl[m] = m_lvl[m] - 1;
        m_ptr[m] = m_sh[m][m_lvl[m]];
      end else begin
        m_shd[m] = 1;
      end
    end else begin
      if (s) begin
        if (m_lvl[m] < NEST) begin
          m_sh[m][m_lvl[m]] = m_ptr[m];
          m_lvl[m] = m_lvl[m] + 1;
        end else begin
          m_shd[m] = 1;
        end
      end
      if (l) begin
        m_ptr[m] = dv;
      end else if (i) begin
        if (depth_now == 0) begin
          m_unf[m] = 1;
          if (wrap) m_ptr[m] = (m_ptr[m] + 1) & MASK;
        end else begin
          m_ptr[m] = (m_ptr[m] + 1) & MASK;
        end
      end else if (d) begin
        if (depth_now >= DEPTH) begin
          m_ovf[m] = 1;
          if (wrap) m_ptr[m] = (m_ptr[m] - 1) & MASK;
        end else begin
          m_ptr[m] = (m_ptr[m] - 1) & MASK;
        end
      end
    end
  endtask

  function automatic exp_t snapshot(input int m);
    exp_t e;
    e.ptr   = m_ptr[m];
    e.cnt   = (EMPTY_VAL - m_ptr[m]) & MASK;
    e.lvl   = m_lvl[m];
    e.empty = (e.cnt == 0);
    e.full  = (e.cnt >= DEPTH);
    e.ovf   = m_ovf[m];
    e.unf   = m_unf[m];
    e.shd   = m_shd[m];
    return e;
  endfunction

  // Drive one cycle of stimulus and post the expected post-edge state.
  task automatic cycle(input bit r, input bit i, input bit d, input bit l, input int dv,
                       input bit s, input bit rs, input bit c);
    @(negedge clk);
    rst = r; inc = i; dec = d; ld = l; din = W'(dv); save = s; restore = rs; clr = c;
    for (int m = 0; m < 2; m++) model_step(m, r, i, d, l, dv, s, rs, c);
    exp_q0.push_back(snapshot(0));
    exp_q1.push_back(snapshot(1));
    @(posedge clk);
    #1;
  endtask

  task automatic compare_dut(input int m, input exp_t e);
    string tag;
    tag = (m == 0) ? "guard" : "wrap";
    check({tag, ".dout"},  int'(dout[m]),  e.ptr);
    check({tag, ".count"}, int'(cnt[m]),   e.cnt);
    check({tag, ".empty"}, int'(empty[m]), int'(e.empty));
    check({tag, ".full"},  int'(full[m]),  int'(e.full));
    check({tag, ".ovf"},   int'(ovf[m]),   int'(e.ovf));
    check({tag, ".unf"},   int'(unf[m]),   int'(e.unf));
    check({tag, ".shd"},   int'(shd[m]),   int'(e.shd));
    check({tag, ".lvl"},   int'(lvl[m]),   e.lvl);
  endtask

  // Monitor: pops one expected entry per DUT after each edge that has one.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q0.size() > 0) begin
        e = exp_q0.pop_front();
        compare_dut(0, e);
      end
      if (exp_q1.size() > 0) begin
        e = exp_q1.pop_front();
        compare_dut(1, e);
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int r, dv;
    rst = 0; inc = 0; dec = 0; ld = 0; din = '0; save = 0; restore = 0; clr = 0;
    for (int m = 0; m < 2; m++) begin
      m_ptr[m] = 0; m_lvl[m] = 0; m_ovf[m] = 0; m_unf[m] = 0; m_shd[m] = 0;
    end

    // Reset dominates concurrent INC/DEC/SAVE.
    cycle(1, 1, 1, 0, 0, 1, 0, 0);
    check("rst_dout", int'(dout[0]), 0);
    check("rst_empty", int'(empty[0]), 1);
    check("rst_lvl", int'(lvl[0]), 0);

    // Push/pop.
    cycle(0, 0, 1, 0, 0, 0, 0, 0);
    check("push1_dout", int'(dout[0]), 'hFF);
    cycle(0, 0, 1, 0, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 0, 0, 0, 0);
    check("push3_dout", int'(dout[0]), 'hFD);
    check("push3_count", int'(cnt[0]), 3);
    cycle(0, 1, 0, 0, 0, 0, 0, 0);
    check("pop_dout", int'(dout[0]), 'hFE);
    cycle(0, 1, 1, 0, 0, 0, 0, 0);
    check("incdec_dout", int'(dout[0]), 'hFF);

    // Guard and wrap boundaries.
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0, 0, 0);
    check("guard_unf_dout", int'(dout[0]), 0);
    check("guard_unf_flag", int'(unf[0]), 1);
    check("wrap_unf_dout", int'(dout[1]), 1);
    check("wrap_unf_full", int'(full[1]), 1);
    check("wrap_unf_count", int'(cnt[1]), 255);
    cycle(0, 0, 0, 1, 'h01, 0, 0, 0);
    check("ld1_full", int'(full[0]), 1);
    cycle(0, 0, 1, 0, 0, 0, 0, 0);
    check("guard_ovf_dout", int'(dout[0]), 1);
    check("guard_ovf_flag", int'(ovf[0]), 1);
    cycle(0, 0, 0, 0, 0, 0, 0, 1);
    check("clr_ovf", int'(ovf[0]), 0);
    check("clr_unf", int'(unf[0]), 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0, 0, 1);
    check("clr_vs_set_unf", int'(unf[0]), 1);

    // Shadow nesting.
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 'hF0, 0, 0, 0);
    cycle(0, 0, 1, 0, 0, 1, 0, 0);
    check("save_dec_dout", int'(dout[0]), 'hEF);
    check("save_dec_lvl", int'(lvl[0]), 1);
    for (int k = 0; k < 3; k++) cycle(0, 0, 1, 0, 0, 1, 0, 0);
    check("save4_lvl", int'(lvl[0]), 4);
    cycle(0, 0, 0, 0, 0, 1, 0, 0);
    check("save5_err", int'(shd[0]), 1);
    check("save5_lvl", int'(lvl[0]), 4);
    for (int k = 0; k < 4; k++) cycle(0, 0, 1, 0, 0, 0, 1, 0);
    check("restore4_dout", int'(dout[0]), 'hF0);
    cycle(0, 0, 0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 0, 1, 0);
    check("restore5_err", int'(shd[0]), 1);
    check("restore5_dout", int'(dout[0]), 'hF0);

    // Reset mid-nesting.
    cycle(0, 0, 0, 1, 'hE0, 1, 0, 0);
    cycle(0, 0, 0, 0, 0, 1, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    check("midrst_dout", int'(dout[0]), 0);
    check("midrst_lvl", int'(lvl[0]), 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 0);
    check("midrst_restore_err", int'(shd[0]), 1);
    check("midrst_restore_dout", int'(dout[0]), 0);

    // Randomised traffic, boundary-biased load values.
    for (int n = 0; n < 2000; n++) begin
      r = $urandom_range(0, 5);
      case (r)
        0: dv = 0;
        1: dv = 1;
        2: dv = 'hFF;
        3: dv = 'hFE;
        default: dv = $urandom_range(0, MASK);
      endcase
      cycle($urandom_range(0, 63) == 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0, dv,
            $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
            $urandom_range(0, 9) == 0);
    end

    @(negedge clk);
    rst = 0; inc = 0; dec = 0; ld = 0; save = 0; restore = 0; clr = 0;
    repeat (2) @(posedge clk);
    #2;
    check("scoreboard_drained", exp_q0.size() + exp_q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
